// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared processor constants for the instruction fetch stage
//
// Purpose : state encoding of the fetch FSM, default reset PC and PC step,
//           and the sequential-PC helper used by the PC register and the
//           IF/ID output registers.
// Ports   : none (package).
package fetch_ctrl_pkg;

  // Fetch FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  // Default first fetch address and sequential increment
  localparam logic [31:0] RESET_PC_DEF = 32'd0;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  // Sequential successor of a fetch address; 32-bit wrap-around is intended
  function automatic logic [31:0] next_seq_pc(input logic [31:0] cur,
                                              input logic [31:0] step);
    return cur + step;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// rtl/fetch_ctrl_pc_reg.sv - fetch PC register with load, increment and hold
//
// Purpose : holds the current fetch address. load has priority over inc;
//           with neither asserted the PC holds.
// Ports   : clk       - system clock, rising edge
//           rst       - asynchronous active-high reset (PC <= RESET_PC)
//           load      - load load_addr into the PC
//           load_addr - redirect target
//           inc       - advance the PC by PC_STEP
//           pc        - current fetch address
module fetch_pc_reg
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= next_seq_pc(pc, PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller (FSM + IF/ID output registers)
//
// Purpose : issues instruction memory requests, delivers fetched words to
//           IF/ID, honours ID-stage stalls and branch redirects.
// Ports   : clk, rst         - clock and asynchronous active-high reset
//           hazard_stall     - ID cannot accept a new instruction
//           branch_taken     - one-cycle redirect request, target branch_addr
//           mem_ready        - memory completes current request, data mem_rdata
//           mem_req/mem_addr - outstanding fetch request and its address
//           instruction/pc   - delivered word and its fetch address + PC_STEP
//           valid            - instruction/pc meaningful this cycle
//           freeze           - PC register not updating this cycle
//           flush            - discard IF/ID contents this cycle
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid,
  output logic        freeze,
  output logic        flush
);

  logic [1:0]  state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic        pc_load, pc_inc;
  logic [31:0] pc_load_addr;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .inc       (pc_inc),
    .pc        (pc_q)
  );

  // pc_inc doubles as "word accepted": only a clean FETCH completion advances.
  always_comb begin
    state_nxt    = state;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load_addr = branch_addr;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          if (branch_taken) begin
            pc_load = 1'b1;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = hazard_stall ? ST_HOLD : ST_FETCH;
          end
        end else if (branch_taken) begin
          state_nxt = ST_DISCARD;
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          pc_load   = 1'b1;
          state_nxt = ST_FETCH;
        end else if (!hazard_stall) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        // A branch arriving together with the stale data still wins.
        if (mem_ready) begin
          pc_load      = 1'b1;
          pc_load_addr = branch_taken ? branch_addr : target_q;
          state_nxt    = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      target_q    <= RESET_PC;
      instruction <= 32'd0;
      pc          <= 32'd0;
      valid       <= 1'b0;
      flush       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (branch_taken && (state == ST_FETCH || state == ST_DISCARD)) begin
        target_q <= branch_addr;
      end
      if (pc_inc) begin
        instruction <= mem_rdata;
        pc          <= next_seq_pc(pc_q, PC_STEP);
      end
      // valid is a per-word pulse, stretched only while HOLD keeps the word
      valid <= pc_inc || (state == ST_HOLD && hazard_stall && !branch_taken);
      flush <= pc_load;
    end
  end

  assign mem_req  = (state == ST_FETCH) || (state == ST_DISCARD);
  assign mem_addr = pc_q;
  assign freeze   = !(pc_load || pc_inc);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;
  logic        freeze;
  logic        flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .hazard_stall (hazard_stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .instruction  (instruction),
    .pc           (pc),
    .valid        (valid),
    .freeze       (freeze),
    .flush        (flush)
  );

  typedef struct {
    logic        rst, hs, bt;
    logic [31:0] ba;
    logic        mr;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins, pcv;
    logic        frz, fl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  function automatic void add(input logic r, input logic hs, input logic bt,
                              input logic [31:0] ba, input logic mr,
                              input logic [31:0] rd, input logic req,
                              input logic [31:0] addr, input logic vld,
                              input logic [31:0] ins, input logic [31:0] pcv,
                              input logic frz, input logic fl);
    vec_t v;
    v.rst = r; v.hs = hs; v.bt = bt; v.ba = ba; v.mr = mr; v.rd = rd;
    v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.pcv = pcv;
    v.frz = frz; v.fl = fl;
    vecs.push_back(v);
  endfunction

  // reset cycle, then the single IDLE cycle with a stray mem_ready
  function automatic void add_rst();
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input int row);
    chk("rst_mem_req", row, 32'(mem_req), 32'd0);
    chk("rst_mem_addr", row, mem_addr, 32'd0);
    chk("rst_instruction", row, instruction, 32'd0);
    chk("rst_pc", row, pc, 32'd0);
    chk("rst_valid", row, 32'(valid), 32'd0);
    chk("rst_freeze", row, 32'(freeze), 32'd1);
    chk("rst_flush", row, 32'(flush), 32'd0);
  endtask

  task automatic apply(input vec_t v, input int row);
    vec_t e;
    @(negedge clk);
    rst = v.rst; hazard_stall = v.hs; branch_taken = v.bt;
    branch_addr = v.ba; mem_ready = v.mr; mem_rdata = v.rd;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    chk("mem_req", row, 32'(mem_req), 32'(e.req));
    chk("mem_addr", row, mem_addr, e.addr);
    chk("valid", row, 32'(valid), 32'(e.vld));
    chk("instruction", row, instruction, e.ins);
    chk("pc", row, pc, e.pcv);
    chk("freeze", row, 32'(freeze), 32'(e.frz));
    chk("flush", row, 32'(flush), 32'(e.fl));
  endtask

  initial begin
    // A: mem_ready tied high after reset
    add_rst();
    add(0, 0, 0, 0, 1, w(0),  1, 0,  0, 0,    0,  0, 0);
    add(0, 0, 0, 0, 1, w(4),  1, 4,  1, w(0), 4,  0, 0);
    add(0, 0, 0, 0, 1, w(8),  1, 8,  1, w(4), 8,  0, 0);
    add(0, 0, 0, 0, 1, w(12), 1, 12, 1, w(8), 12, 0, 0);
    // B: memory wait states at address 8
    add_rst();
    add(0, 0, 0, 0, 1, w(0), 1, 0,  0, 0,    0,  0, 0);
    add(0, 0, 0, 0, 1, w(4), 1, 4,  1, w(0), 4,  0, 0);
    add(0, 0, 0, 0, 0, 0,    1, 8,  1, w(4), 8,  1, 0);
    add(0, 0, 0, 0, 0, 0,    1, 8,  0, w(4), 8,  1, 0);
    add(0, 0, 0, 0, 0, 0,    1, 8,  0, w(4), 8,  1, 0);
    add(0, 0, 0, 0, 1, w(8), 1, 8,  0, w(4), 8,  0, 0);
    add(0, 0, 0, 0, 0, 0,    1, 12, 1, w(8), 12, 1, 0);
    // C: hazard stall while the word at 4 returns
    add_rst();
    add(0, 0, 0, 0, 1, w(0), 1, 0,  0, 0,    0,  0, 0);
    add(0, 1, 0, 0, 1, w(4), 1, 4,  1, w(0), 4,  0, 0);
    add(0, 1, 0, 0, 0, 0,    0, 8,  1, w(4), 8,  1, 0);
    add(0, 0, 0, 0, 0, 0,    0, 8,  1, w(4), 8,  1, 0);
    add(0, 0, 0, 0, 1, w(8), 1, 8,  0, w(4), 8,  0, 0);
    add(0, 0, 0, 0, 0, 0,    1, 12, 1, w(8), 12, 1, 0);
    // D: branch to 0x40 while request to 12 is pending
    add_rst();
    add(0, 0, 0, 0,     1, w(0), 1, 0,     0, 0,       0,     0, 0);
    add(0, 0, 0, 0,     1, w(4), 1, 4,     1, w(0),    4,     0, 0);
    add(0, 0, 0, 0,     1, w(8), 1, 8,     1, w(4),    8,     0, 0);
    add(0, 0, 1, 'h40,  0, 0,    1, 12,    1, w(8),    12,    1, 0);
    add(0, 0, 0, 0,     0, 0,    1, 12,    0, w(8),    12,    1, 0);
    add(0, 0, 0, 0,     1, 32'hDEAD_BEEF, 1, 12, 0, w(8), 12, 0, 0);
    add(0, 0, 0, 0,     0, 0,    1, 'h40,  0, w(8),    12,    1, 1);
    add(0, 0, 0, 0,     1, w('h40), 1, 'h40, 0, w(8),  12,    0, 0);
    add(0, 0, 0, 0,     0, 0,    1, 'h44,  1, w('h40), 'h44,  1, 0);
    // E: branch with ready in same cycle, then last-target-wins in DISCARD
    add_rst();
    add(0, 0, 0, 0,      1, w(0), 1, 0,      0, 0,        0,      0, 0);
    add(0, 0, 1, 'h100,  1, 32'h0BAD_0BAD, 1, 4, 1, w(0), 4,      0, 0);
    add(0, 0, 0, 0,      0, 0,    1, 'h100,  0, w(0),     4,      1, 1);
    add(0, 0, 0, 0,      1, w('h100), 1, 'h100, 0, w(0),  4,      0, 0);
    add(0, 0, 1, 'h200,  0, 0,    1, 'h104,  1, w('h100), 'h104,  1, 0);
    add(0, 0, 1, 'h300,  0, 0,    1, 'h104,  0, w('h100), 'h104,  1, 0);
    add(0, 0, 0, 0,      1, 32'h0BAD_0BAD, 1, 'h104, 0, w('h100), 'h104, 0, 0);
    add(0, 0, 0, 0,      0, 0,    1, 'h300,  0, w('h100), 'h104,  1, 1);
    add(0, 0, 0, 0,      0, 0,    1, 'h300,  0, w('h100), 'h104,  1, 0);
    // F: branch during HOLD, then a branch to the top of memory and wrap
    add_rst();
    add(0, 1, 0, 0,      1, w(0), 1, 0,     0, 0,    0, 0, 0);
    add(0, 1, 1, 'h500,  0, 0,    0, 4,     1, w(0), 4, 0, 0);
    add(0, 0, 0, 0,      0, 0,    1, 'h500, 0, w(0), 4, 1, 1);
    add(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0BAD_0BAD, 1, 'h500, 0, w(0), 4, 0, 0);
    add(0, 0, 0, 0, 1, w(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 0, w(0), 4, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, w(32'hFFFF_FFFC), 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // G: reset asserted mid-DISCARD with mem_ready pulsed during reset
    vecs.delete();
    add_rst();
    add(0, 0, 0, 0,     1, w(0), 1, 0, 0, 0,    0, 0, 0);
    add(0, 0, 1, 'h80,  0, 0,    1, 4, 1, w(0), 4, 1, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], 1000 + i);
    end
    @(negedge clk);
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("g_discard_req", 2000, 32'(mem_req), 32'd1);
    chk("g_discard_addr", 2000, mem_addr, 32'd4);
    #1;
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    #1;
    check_reset_outputs(2001);
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs(2002);
    @(negedge clk);
    rst = 1'b0;
    mem_rdata = w(0);
    #1;
    chk("g_idle_req", 2003, 32'(mem_req), 32'd0);
    chk("g_idle_valid", 2003, 32'(valid), 32'd0);
    chk("g_idle_freeze", 2003, 32'(freeze), 32'd1);
    @(negedge clk);
    #1;
    chk("g_first_req", 2004, 32'(mem_req), 32'd1);
    chk("g_first_addr", 2004, mem_addr, 32'd0);
    begin
      int k = 0;
      while (!valid && k < 10) begin
        @(negedge clk);
        #1;
        k++;
      end
    end
    chk("g_valid", 2005, 32'(valid), 32'd1);
    chk("g_instruction", 2005, instruction, w(0));
    chk("g_pc", 2005, pc, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, meaning the first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 32'd4, meaning the sequential PC increment.
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, asynchronous and active-high.
REQ-005 SHALL have port hazard_stall  input  1  meaning the ID stage cannot accept a new instruction this cycle.
REQ-006 SHALL have port branch_taken  input  1  meaning a redirect request, valid for one cycle.
REQ-007 SHALL have port branch_addr  input  32  meaning the redirect target, sampled when branch_taken=1.
REQ-008 SHALL have port mem_ready  input  1  meaning instruction memory completes the current request this cycle.
REQ-009 SHALL have port mem_rdata  input  32  meaning the fetched word, valid when mem_ready=1.
REQ-010 SHALL have port mem_req  output  1  meaning a fetch request is outstanding.
REQ-011 SHALL have port mem_addr  output  32  meaning the fetch address.
REQ-012 SHALL have port instruction  output  32  meaning the instruction delivered to IF/ID.
REQ-013 SHALL have port pc  output  32  meaning the fetch address plus PC_STEP for the delivered instruction.
REQ-014 SHALL have port valid  output  1  meaning instruction and pc are meaningful this cycle.
REQ-015 SHALL have port freeze  output  1  meaning the PC is not advancing this cycle.
REQ-016 SHALL have port flush  output  1  meaning IF/ID contents are to be discarded this cycle.

Function
REQ-017 SHALL implement states IDLE, FETCH, HOLD and DISCARD; IDLE lasts exactly one cycle after reset release, then goes to FETCH.
REQ-018 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal the internal PC; mem_req and mem_addr SHALL stay stable until mem_ready=1.
REQ-019 FETCH with mem_ready=1, branch_taken=0 and hazard_stall=0 SHALL register mem_rdata into instruction, PC+PC_STEP into pc, and valid=1 the next cycle; the PC SHALL advance by PC_STEP (32-bit wrap-around) and the state SHALL stay FETCH.
REQ-020 FETCH with mem_ready=1, branch_taken=0 and hazard_stall=1 SHALL capture the word, advance the PC and enter HOLD.
REQ-021 In HOLD, mem_req SHALL be 0, and instruction, pc and valid=1 SHALL be held; the state SHALL return to FETCH in the cycle after hazard_stall deasserts.
REQ-022 FETCH with branch_taken=1 and mem_ready=1 SHALL drop mem_rdata, load the PC with branch_addr, pulse flush the next cycle and stay in FETCH.
REQ-023 FETCH with branch_taken=1 and mem_ready=0 SHALL store branch_addr and enter DISCARD.
REQ-024 In DISCARD, the old request SHALL be held until mem_ready=1; the returned data SHALL be dropped, the PC SHALL be loaded with the stored target, flush SHALL pulse, and the state SHALL become FETCH.
REQ-025 A further branch_taken in DISCARD SHALL overwrite the stored target (last one wins).
REQ-026 branch_taken in HOLD SHALL take priority over hazard_stall: the PC is loaded with branch_addr, valid clears, flush pulses, and the state becomes FETCH.
REQ-027 valid SHALL be 0 in every cycle after a flush pulse until the next accepted word.
REQ-028 freeze SHALL be combinational and equal 1 in every cycle in which the PC register does not update.
REQ-029 flush SHALL be a registered one-cycle pulse and SHALL never assert for two consecutive cycles from a single branch.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, PC=RESET_PC, mem_req=0, mem_addr=RESET_PC, instruction=0, pc=0, valid=0, flush=0 and freeze=1.
REQ-031 rst asserted mid-request SHALL abandon the request; any late mem_ready SHALL be ignored until the state is FETCH.

Structure
REQ-032 The state encoding and the RESET_PC and PC_STEP defaults SHALL live in the shared processor package.
REQ-033 The PC register with load, increment and hold SHALL be the single sub-module fetch_pc_reg; the FSM and the output registers SHALL stay in fetch_ctrl.

Verification
REQ-034 Reset release with mem_ready tied to 1 -> mem_addr sequence 0,4,8,12; pc outputs 4,8,12; valid=1 from the third cycle.
REQ-035 mem_ready low for 3 cycles at address 8 -> mem_req=1 with mem_addr=8 stable for all 3 cycles, freeze=1, and no valid pulse until 1 cycle after ready.
REQ-036 hazard_stall=1 for 2 cycles while the word at address 4 returns -> instruction and pc=8 held, mem_req=0, then fetch resumes at address 8.
REQ-037 branch_taken with branch_addr=0x40 while the request to address 12 is pending 2 cycles -> data from 12 dropped, one flush pulse, next mem_addr=0x40.
REQ-038 branch_taken and mem_ready in the same cycle, and separately a branch during HOLD -> flush pulses once, valid=0, and the next fetch uses the branch target.
REQ-039 Reset asserted mid-DISCARD with mem_ready pulsed during reset -> all outputs at reset values, and the first fetch is at RESET_PC.
